// File: rtl/dec_pr_pkg.sv
// Shared posit register file definitions: widths and the writeback payload.
package dec_pr_pkg;

    localparam int unsigned PR_ADDR_W = 5;
    localparam int unsigned PR_DATA_W = 32;
    localparam int unsigned PR_NUM    = 32;

    // One register file write: destination and value.
    typedef struct packed {
        logic [PR_ADDR_W-1:0] rd;
        logic [PR_DATA_W-1:0] data;
    } pr_wb_t;

    // PR0 is hardwired zero; anything targeting it is discarded.
    function automatic logic is_zero_pr(input logic [PR_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/dec_pr_wb_fifo.sv
// Ordered buffer of posit-unit results waiting for the register file write port.
module dec_pr_wb_fifo
    import dec_pr_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  pr_wb_t           din,
    output pr_wb_t           dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pr_wb_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dec_pr_wb_ctl.sv
// Posit register file writeback controller: arbitrates load and posit-unit
// results onto the single write port and tracks pending destinations.
module dec_pr_wb_ctl
    import dec_pr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [PR_ADDR_W-1:0] issue_rd,
    input  logic [PR_ADDR_W-1:0] issue_rs1,
    input  logic [PR_ADDR_W-1:0] issue_rs2,
    output logic                 issue_stall,
    input  logic                 pu_valid,
    input  logic [PR_ADDR_W-1:0] pu_rd,
    input  logic [PR_DATA_W-1:0] pu_data,
    output logic                 pu_ready,
    input  logic                 ld_valid,
    input  logic [PR_ADDR_W-1:0] ld_rd,
    input  logic [PR_DATA_W-1:0] ld_data,
    output logic                 pr_wen,
    output logic [PR_ADDR_W-1:0] pr_waddr,
    output logic [PR_DATA_W-1:0] pr_wd,
    output logic [31:1]          busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    pr_wb_t            fifo_dout;
    pr_wb_t            pu_item;
    pr_wb_t            ld_item;
    pr_wb_t            sel;
    logic              sel_valid;
    logic              fifo_push;
    logic              fifo_pop;
    logic              bypass;
    logic              ld_wr;
    logic              pu_xfer;
    logic              issue_acc;
    logic [31:0]       busy_vec;
    logic [31:1]       busy_q;
    logic [31:1]       busy_nxt;

    assign pu_item  = '{rd: pu_rd, data: pu_data};
    assign ld_item  = '{rd: ld_rd, data: ld_data};
    assign pu_ready = ~fifo_full;
    assign busy     = busy_q;

    // PR0 reads as never busy so sources/destinations of zero cannot hazard.
    assign busy_vec = {busy_q, 1'b0};

    // Results targeting PR0 are swallowed before arbitration.
    assign ld_wr   = ld_valid & ~is_zero_pr(ld_rd);
    assign pu_xfer = pu_valid & pu_ready & ~is_zero_pr(pu_rd);

    // Hazard and backpressure stall seen by decode.
    assign issue_stall = busy_vec[issue_rs1] | busy_vec[issue_rs2] | busy_vec[issue_rd]
                       | (fifo_count == CNT_W'(FIFO_DEPTH));
    assign issue_acc   = issue_valid & ~issue_stall;

    // Write-port arbitration: load, then oldest buffered result, then bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel       = ld_item;
        fifo_pop  = 1'b0;
        bypass    = 1'b0;
        if (ld_wr) begin
            sel_valid = 1'b1;
            sel       = ld_item;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel       = fifo_dout;
            fifo_pop  = 1'b1;
        end else if (pu_xfer) begin
            sel_valid = 1'b1;
            sel       = pu_item;
            bypass    = 1'b1;
        end
        fifo_push = pu_xfer & ~bypass;
    end

    dec_pr_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pu_item),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pr_wen   <= 1'b0;
            pr_waddr <= '0;
            pr_wd    <= '0;
        end else begin
            pr_wen <= sel_valid;
            if (sel_valid) begin
                pr_waddr <= sel.rd;
                pr_wd    <= sel.data;
            end
        end
    end

    // Scoreboard update: clear on the write cycle, set on accepted issue (set wins).
    always_comb begin
        busy_nxt = busy_q;
        for (int i = 1; i < int'(PR_NUM); i++) begin
            busy_nxt[i] = (busy_q[i] & ~(pr_wen && (pr_waddr == PR_ADDR_W'(i))))
                        | (issue_acc && (issue_rd == PR_ADDR_W'(i)));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dec_pr_wb_ctl.sv
// Self-checking bench for dec_pr_wb_ctl: stall vector table, ordered
// writeback scoreboard and hand-written multi-cycle sequences.
module tb_dec_pr_wb_ctl;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        pu_valid;
    logic [4:0]  pu_rd;
    logic [31:0] pu_data;
    logic        pu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        pr_wen;
    logic [4:0]  pr_waddr;
    logic [31:0] pr_wd;
    logic [31:1] busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];
    vec_t vt[8];

    dec_pr_wb_ctl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .pu_valid(pu_valid), .pu_rd(pu_rd), .pu_data(pu_data), .pu_ready(pu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .pr_wen(pr_wen), .pr_waddr(pr_waddr), .pr_wd(pr_wd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bz(input int r);
        return 32'(1) << (r - 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        pu_valid = 1'b0; pu_rd = '0; pu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Every register file write must match the next expected write, in order.
    always @(negedge clk) begin : wb_monitor
        exp_t e;
        if (pr_wen === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         pr_waddr, pr_wd);
            end else begin
                e = sbq.pop_front();
                chk("wb_addr", 32'(pr_waddr), 32'(e.rd));
                chk("wb_data", pr_wd, e.data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  j;
        logic xfer;

        vt[0] = '{rs1: 5'd3,  rs2: 5'd0,  rd: 5'd1,  stall: 1'b1};
        vt[1] = '{rs1: 5'd0,  rs2: 5'd3,  rd: 5'd1,  stall: 1'b1};
        vt[2] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd3,  stall: 1'b1};
        vt[3] = '{rs1: 5'd7,  rs2: 5'd0,  rd: 5'd2,  stall: 1'b1};
        vt[4] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd0,  stall: 1'b0};
        vt[5] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd4,  stall: 1'b0};
        vt[6] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd29, stall: 1'b0};
        vt[7] = '{rs1: 5'd0,  rs2: 5'd7,  rd: 5'd0,  stall: 1'b1};

        // Reset state.
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wen", 32'(pr_wen), 0);
        chk("rst_waddr", 32'(pr_waddr), 0);
        chk("rst_wd", pr_wd, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pu_ready", 32'(pu_ready), 1);
        chk("rst_stall", 32'(issue_stall), 0);

        // Issue rd=5, then its posit-unit result bypasses straight to the port.
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 chk("s1_stall", 32'(issue_stall), 0);
        tick();
        chk("s1_busy_set", 32'(busy), bz(5));
        idle();
        pu_valid = 1'b1; pu_rd = 5'd5; pu_data = 32'h4000_0000;
        expect_wb(5'd5, 32'h4000_0000);
        #1 chk("s1_pu_ready", 32'(pu_ready), 1);
        tick();
        idle();
        issue_rs1 = 5'd5;
        #1;
        chk("s1_wen", 32'(pr_wen), 1);
        chk("s1_waddr", 32'(pr_waddr), 5);
        chk("s1_wd", pr_wd, 32'h4000_0000);
        chk("s1_busy_held", 32'(busy), bz(5));
        chk("s1_raw_stall", 32'(issue_stall), 1);
        tick();
        chk("s1_busy_clr", 32'(busy), 0);
        chk("s1_unstall", 32'(issue_stall), 0);

        // Hazard table with PR3 and PR7 pending.
        idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd7;
        tick();
        idle();
        chk("s2_busy", 32'(busy), bz(3) | bz(7));
        for (int k = 0; k < 8; k++) begin
            issue_rs1 = vt[k].rs1; issue_rs2 = vt[k].rs2; issue_rd = vt[k].rd;
            #1 chk($sformatf("s2_vec%0d", k), 32'(issue_stall), 32'(vt[k].stall));
        end

        // RAW on PR3 holds until the cycle after its write.
        idle();
        @(posedge clk); #2;
        issue_valid = 1'b1; issue_rs1 = 5'd3;
        pu_valid = 1'b1; pu_rd = 5'd3; pu_data = 32'h33;
        expect_wb(5'd3, 32'h33);
        #1 chk("s2_stall_a", 32'(issue_stall), 1);
        tick();
        pu_valid = 1'b0;
        #1 chk("s2_stall_b", 32'(issue_stall), 1);
        tick();
        chk("s2_stall_c", 32'(issue_stall), 0);
        tick();
        idle();
        chk("s2_busy_after", 32'(busy), bz(7));
        pu_valid = 1'b1; pu_rd = 5'd7; pu_data = 32'h77;
        expect_wb(5'd7, 32'h77);
        tick();
        idle();
        tick(); tick();
        chk("s2_busy_clean", 32'(busy), 0);

        // Six back-to-back loads while the posit unit offers PR1..PR5.
        for (int k = 0; k < 6; k++) expect_wb(5'(10 + k), 32'hA0 + 32'(k));
        for (int k = 0; k < 5; k++) expect_wb(5'(1 + k), 32'h100 + 32'(k));
        j = 0;
        for (int c = 0; c < 20 && (c < 6 || j < 5); c++) begin
            ld_valid = (c < 6); ld_rd = 5'(10 + c); ld_data = 32'hA0 + 32'(c);
            pu_valid = (j < 5); pu_rd = 5'(j + 1); pu_data = 32'h100 + 32'(j);
            #1;
            if (c == 4 || c == 5 || c == 6) chk($sformatf("s3_ready_c%0d", c), 32'(pu_ready), 0);
            if (c == 3 || c == 7) chk($sformatf("s3_ready_c%0d", c), 32'(pu_ready), 1);
            if (c == 4) chk("s3_full_stall", 32'(issue_stall), 1);
            xfer = pu_valid & pu_ready;
            tick();
            if (xfer) j++;
        end
        chk("s3_all_sent", j, 5);
        idle();
        repeat (8) tick();
        chk("s3_drained", sbq.size(), 0);

        // Load and posit-unit result together with the FIFO empty.
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hD0;
        pu_valid = 1'b1; pu_rd = 5'd21; pu_data = 32'hE0;
        expect_wb(5'd20, 32'hD0);
        expect_wb(5'd21, 32'hE0);
        tick();
        idle();
        chk("s4_first", 32'(pr_waddr), 20);
        tick();
        chk("s4_second_wen", 32'(pr_wen), 1);
        chk("s4_second", 32'(pr_waddr), 21);
        tick();
        chk("s4_idle", 32'(pr_wen), 0);

        // Results and issues targeting PR0 are ignored.
        pu_valid = 1'b1; pu_rd = 5'd0; pu_data = 32'hDEAD;
        tick();
        idle();
        chk("s5_pu_zero", 32'(pr_wen), 0);
        ld_valid = 1'b1;
        tick();
        idle();
        chk("s5_no_late_pop", 32'(pr_wen), 0);
        chk("s5_ready", 32'(pu_ready), 1);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        chk("s5_ld_zero", 32'(pr_wen), 0);
        chk("s5_issue_zero", 32'(busy), 0);

        // Reset with three buffered results and a pending destination.
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            ld_valid = 1'b1; ld_rd = 5'(25 + c); ld_data = 32'hC5 + 32'(c);
            pu_valid = 1'b1; pu_rd = 5'(1 + c); pu_data = 32'h201 + 32'(c);
            expect_wb(5'(25 + c), 32'hC5 + 32'(c));
            tick();
        end
        idle();
        rst = 1'b1;
        #1;
        chk("s6_pre_ready", 32'(pu_ready), 1);
        chk("s6_pre_busy", 32'(busy), bz(9));
        tick();
        issue_rs1 = 5'd9;
        #1;
        chk("s6_busy", 32'(busy), 0);
        chk("s6_wen", 32'(pr_wen), 0);
        chk("s6_ready", 32'(pu_ready), 1);
        chk("s6_stall", 32'(issue_stall), 0);
        rst = 1'b0;
        idle();
        repeat (6) tick();
        chk("s6_no_stale_writes", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_pr_wb_ctl.md
# dec_pr_wb_ctl

Writeback controller for the posit register file: merges posit-unit results and posit-load results onto the register file's single write port, buffering posit-unit results in a 4-entry FIFO while loads own the port. Keeps a 31-bit busy scoreboard of pending destinations and stalls decode issue on RAW/WAW hazards. Sits between the posit execution/load pipes and the posit register file write port (`wen`/`waddr`/`wd`).

## Interface
- `FIFO_DEPTH`, 4: posit-unit result buffer entries; power of two, ≥2.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `issue_valid`  in  1  decode issues a posit op writing a PR; counted only when `issue_stall`=0.
- `issue_rd`  in  5  destination PR.
- `issue_rs1`, `issue_rs2`  in  5 each  source PRs.
- `issue_stall`  out  1  hazard/backpressure stall to decode (combinational).
- `pu_valid`  in  1  posit-unit result valid.
- `pu_rd`  in  5  result destination.
- `pu_data`  in  32  result.
- `pu_ready`  out  1  FIFO can accept; transfer = `pu_valid & pu_ready`.
- `ld_valid`  in  1  posit-load result valid; no backpressure.
- `ld_rd`  in  5,  `ld_data`  in  32.
- `pr_wen`  out  1  register file write enable (registered).
- `pr_waddr`  out  5,  `pr_wd`  out  32  register file write address/data (registered).
- `busy`  out  31  scoreboard, bit i = PR i pending (bits 31:1).

## Operation
- PR0 is hardwired zero: results with rd=0 are dropped (no write, no FIFO entry); issue with rd=0 sets no busy bit; rs=0 never hazards.
- `issue_stall` = busy[rs1] | busy[rs2] | busy[rd] | (FIFO count == FIFO_DEPTH). Evaluate busy on current register state.
- Accepted issue (`issue_valid & ~issue_stall`, rd≠0) sets busy[rd] at the next edge.
- Write-port arbitration each cycle, priority: (1) `ld_valid` → load result; (2) FIFO non-empty → pop head; (3) `pu_valid` with FIFO empty → bypass directly; else no write.
- A `pu` transfer is pushed to the FIFO when it is not selected for bypass this cycle. Push and pop in the same cycle are legal, including at full (pop frees slot; `pu_ready` = count<DEPTH | pop this cycle is NOT used — `pu_ready` = count<DEPTH only).
- FIFO: `FIFO_DEPTH` entries {rd, data}, read/write pointers wrap modulo depth, count 0..DEPTH; order strictly preserved.
- Selected result is registered into `pr_wen/pr_waddr/pr_wd`; busy[waddr] clears at the edge ending the cycle `pr_wen`=1.
- Set and clear of the same bit in one cycle cannot occur (issue stalls on busy rd); if it does, set wins.
- Load to a non-busy PR writes normally; no busy change beyond clear.

## Timing
- Reset values: `pr_wen`=0, `pr_waddr`=0, `pr_wd`=0, `busy`=0, FIFO count=0, pointers=0; hence `pu_ready`=1, `issue_stall`=0 (given quiet inputs).
- Result valid in cycle N (selected) → `pr_wen`=1 in N+1 → busy cleared, dependent issue unstalled in N+2.
- Result queued behind a load: written at earliest one cycle after the last consecutive load cycle, in FIFO order.
- Reset in mid-operation discards FIFO contents and scoreboard; `pr_wen` deasserted the cycle after `rst` is sampled.

## Structure
- Shared package `dec_pr_pkg`: `PR_ADDR_W`=5, `PR_DATA_W`=32, typedef `pr_wb_t` {rd, data}; also used by the posit unit and register file.
- One sub-module: `dec_pr_wb_fifo` (parameterised depth, push/pop/count/full/empty, carries `pr_wb_t`).

## Test plan
- Reset, then issue rd=5, `pu` result rd=5 data=0x4000_0000 → `pr_wen`=1, waddr=5, wd=0x4000_0000 next cycle; busy[5] clear one cycle later.
- Issue rd=3, then issue rs1=3 while pending → `issue_stall`=1 until cycle after write of PR3.
- `ld_valid` for 6 consecutive cycles while `pu` sends rd=1..5 → FIFO fills at 4, `pu_ready`=0 on 5th; after loads stop, PR1..4 then PR5 written in order.
- `pu` and `ld` valid same cycle, FIFO empty → load written first, `pu` result written next cycle.
- Result with rd=0 → no `pr_wen`, FIFO count unchanged; issue rd=0 → busy unchanged.
- Assert `rst` with FIFO count 3 and busy bits set → next cycle count=0, busy=0, `pr_wen`=0, `pu_ready`=1.
